// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: bundles the control, RAM-port and decode-side signals of
// one core's fetch stage. The slave modport belongs to inst_fetch_unit, and the
// master modport belongs to whatever drives it (control unit plus RAM port).
// When INST_FETCH_PERF_EN is defined, the bundle also carries the
// fetch_cnt/stall_cnt performance counters.
interface inst_fetch_unit_if;
  logic        start;
  logic        stall;
  logic        pc_load;
  logic [5:0]  pc_load_val;
  logic [5:0]  pc_out;
  logic [20:0] ins_in;
  logic [20:0] ir_out;
  logic        ir_valid;
  logic        halted;
  logic        addr_err;
  logic        busy;
`ifdef INST_FETCH_PERF_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;

  modport master (
    output start, stall, pc_load, pc_load_val, ins_in,
    input  pc_out, ir_out, ir_valid, halted, addr_err, busy, fetch_cnt, stall_cnt
  );

  modport slave (
    input  start, stall, pc_load, pc_load_val, ins_in,
    output pc_out, ir_out, ir_valid, halted, addr_err, busy, fetch_cnt, stall_cnt
  );
`else
  modport master (
    output start, stall, pc_load, pc_load_val, ins_in,
    input  pc_out, ir_out, ir_valid, halted, addr_err, busy
  );

  modport slave (
    input  start, stall, pc_load, pc_load_val, ins_in,
    output pc_out, ir_out, ir_valid, halted, addr_err, busy
  );
`endif
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: per-core fetch stage. It owns the 6-bit PC, addresses one
// combinational read port of the instruction RAM, and registers the returned
// word into the IR for decode. It handles stall, jump loads with a one-cycle
// flush, halt-opcode detection and an out-of-range address trap.
// Optional macro INST_FETCH_PERF_EN adds saturating fetch/stall cycle counters.
module inst_fetch_unit #(
  parameter int         MEM_DEPTH = 52,
  parameter logic [5:0] START_PC  = 6'd0,
  parameter logic [5:0] HALT_OP   = 6'b000100
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_fetch_unit_if.slave fetch_bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Depth is widened by one bit so that MEM_DEPTH = 64 still compares correctly.
  localparam logic [6:0] DEPTH_EXT = 7'(MEM_DEPTH);
  localparam logic [5:0] LAST_PC   = 6'(MEM_DEPTH - 1);

  state_t      state_q, state_d;
  logic [5:0]  pc_q, pc_d;
  logic [20:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        load_bad;
  logic        is_halt_op;
  logic        at_last;

  assign load_bad   = {1'b0, fetch_bus.pc_load_val} >= DEPTH_EXT;
  assign is_halt_op = fetch_bus.ins_in[20:15] == HALT_OP;
  assign at_last    = ({1'b0, pc_q} + 7'd1) >= DEPTH_EXT;

  // State, PC, IR, valid flag and sticky error register with async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      ir_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: in FETCH/STALL, pc_load wins over stall, and a released stall captures immediately
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (fetch_bus.start) begin
          state_d = FETCH;
          pc_d    = START_PC;
        end
      end
      FETCH, STALL: begin
        if (fetch_bus.pc_load) begin
          valid_d = 1'b0;
          if (load_bad) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = fetch_bus.pc_load_val;
            state_d = fetch_bus.stall ? STALL : FETCH;
          end
        end else if (fetch_bus.stall) begin
          state_d = STALL;
        end else begin
          ir_d    = fetch_bus.ins_in;
          valid_d = 1'b1;
          if (is_halt_op) begin
            state_d = HALT;
          end else if (at_last) begin
            err_d   = 1'b1;
            pc_d    = LAST_PC;
            state_d = HALT;
          end else begin
            pc_d    = pc_q + 6'd1;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fetch_bus.pc_out   = pc_q;
  assign fetch_bus.ir_out   = ir_q;
  assign fetch_bus.ir_valid = valid_q;
  assign fetch_bus.addr_err = err_q;
  assign fetch_bus.halted   = state_q == HALT;
  assign fetch_bus.busy     = (state_q == FETCH) || (state_q == STALL);

`ifdef INST_FETCH_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating counters of valid-IR cycles and cycles spent in STALL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (valid_q && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      if ((state_q == STALL) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_bus.fetch_cnt = fetch_cnt_q;
  assign fetch_bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios plus randomized traffic for
// inst_fetch_unit. Outputs are compared against a behavioural model that only
// knows whether the core is idle, running or halted.
module tb_inst_fetch_unit;
  localparam int         MEM_DEPTH = 52;
  localparam logic [5:0] HALT_OP   = 6'b000100;

  logic clk = 1'b0;
  logic rst_n;
  logic [20:0] ram [0:63];
  int checks = 0;
  int errors = 0;

  inst_fetch_unit_if bus();

  inst_fetch_unit #(.MEM_DEPTH(MEM_DEPTH), .START_PC(6'd0), .HALT_OP(HALT_OP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.ins_in = ram[bus.pc_out];

  // Behavioural reference: a running core either loads, holds, or consumes one word
  typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
  mode_t       m_mode;
  int          m_pc;
  logic [20:0] m_ir;
  bit          m_valid;
  bit          m_err;
  bit          m_stalled;
  int          m_fetch;
  int          m_stall;

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_ir = '0; m_valid = 0; m_err = 0;
    m_stalled = 0; m_fetch = 0; m_stall = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.stall = 0; bus.pc_load = 0; bus.pc_load_val = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_ram_linear();
    for (int a = 0; a < 64; a++) ram[a] = 21'(a);
  endtask

  // Drives one cycle of inputs, advances the model at the edge, returns at the next negedge
  task automatic step(input bit st, input bit sl, input bit ld, input logic [5:0] val);
    bus.start = st; bus.stall = sl; bus.pc_load = ld; bus.pc_load_val = val;
    @(posedge clk);
    if (m_valid && m_fetch < 65535) m_fetch++;
    if (m_stalled && m_stall < 65535) m_stall++;
    m_stalled = 0;
    case (m_mode)
      M_IDLE: if (st) begin m_mode = M_RUN; m_pc = 0; end
      M_RUN: begin
        if (ld) begin
          m_valid = 0;
          if (int'(val) >= MEM_DEPTH) begin m_err = 1; m_mode = M_HALT; end
          else begin m_pc = int'(val); m_stalled = sl; end
        end else if (sl) begin
          m_stalled = 1;
        end else begin
          m_ir = ram[m_pc];
          m_valid = 1;
          if (m_ir[20:15] == HALT_OP) m_mode = M_HALT;
          else if (m_pc + 1 >= MEM_DEPTH) begin m_err = 1; m_mode = M_HALT; end
          else m_pc = m_pc + 1;
        end
      end
      default: m_valid = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.stall = 0; bus.pc_load = 0; bus.pc_load_val = '0;
    #3;
    checks++; if (bus.pc_out !== 6'd0) begin errors++; $display("[TB] FAIL reset_pc: got %0d expected 0", bus.pc_out); end
    checks++; if (bus.ir_out !== 21'd0) begin errors++; $display("[TB] FAIL reset_ir: got %0h expected 0", bus.ir_out); end
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.ir_valid); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", bus.halted); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.addr_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    apply_reset();
    step(0, 1, 1, 6'd9);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_ignore_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.pc_out !== 6'd0) begin errors++; $display("[TB] FAIL idle_ignore_pc: got %0d expected 0", bus.pc_out); end
  endtask

  task automatic test_sequential();
    fill_ram_linear();
    apply_reset();
    step(1, 0, 0, 6'd0);
    checks++; if (bus.pc_out !== 6'd0 || bus.busy !== 1'b1 || bus.ir_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL start: got pc=%0d busy=%b valid=%b expected pc=0 busy=1 valid=0", bus.pc_out, bus.busy, bus.ir_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 6'd0);
      checks++; if (bus.ir_out !== 21'(i) || bus.ir_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL seq_word: got ir=%0d valid=%b expected ir=%0d valid=1", bus.ir_out, bus.ir_valid, i);
      end
      checks++; if (bus.pc_out !== 6'(i + 1)) begin errors++; $display("[TB] FAIL seq_pc: got %0d expected %0d", bus.pc_out, i + 1); end
    end
  endtask

  // Continues from pc_out=5 left by test_sequential
  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 6'd0);
      checks++; if (bus.pc_out !== 6'd5 || bus.ir_out !== 21'd4 || bus.busy !== 1'b1) begin
        errors++; $display("[TB] FAIL stall_hold: got pc=%0d ir=%0d busy=%b expected pc=5 ir=4 busy=1", bus.pc_out, bus.ir_out, bus.busy);
      end
    end
    step(0, 0, 0, 6'd0);
    checks++; if (bus.ir_out !== 21'd5 || bus.ir_valid !== 1'b1 || bus.pc_out !== 6'd6) begin
      errors++; $display("[TB] FAIL stall_release: got ir=%0d valid=%b pc=%0d expected ir=5 valid=1 pc=6", bus.ir_out, bus.ir_valid, bus.pc_out);
    end
    step(0, 0, 0, 6'd0);
  endtask

  // Continues from pc_out=7
  task automatic test_jump();
    step(0, 0, 1, 6'd20);
    checks++; if (bus.ir_valid !== 1'b0 || bus.pc_out !== 6'd20 || bus.ir_out !== 21'd6) begin
      errors++; $display("[TB] FAIL jump_flush: got valid=%b pc=%0d ir=%0d expected valid=0 pc=20 ir=6", bus.ir_valid, bus.pc_out, bus.ir_out);
    end
    step(0, 0, 0, 6'd0);
    checks++; if (bus.ir_out !== 21'd20 || bus.ir_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL jump_target: got ir=%0d valid=%b expected ir=20 valid=1", bus.ir_out, bus.ir_valid);
    end
  endtask

  task automatic test_priority();
    step(0, 1, 1, 6'd10);
    checks++; if (bus.pc_out !== 6'd10 || bus.ir_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL prio_load: got pc=%0d valid=%b busy=%b expected pc=10 valid=0 busy=1", bus.pc_out, bus.ir_valid, bus.busy);
    end
    step(0, 1, 0, 6'd0);
    checks++; if (bus.pc_out !== 6'd10 || bus.ir_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_hold: got pc=%0d valid=%b expected pc=10 valid=0", bus.pc_out, bus.ir_valid);
    end
    step(0, 0, 0, 6'd0);
    checks++; if (bus.ir_out !== 21'd10 || bus.ir_valid !== 1'b1 || bus.pc_out !== 6'd11) begin
      errors++; $display("[TB] FAIL prio_release: got ir=%0d valid=%b pc=%0d expected ir=10 valid=1 pc=11", bus.ir_out, bus.ir_valid, bus.pc_out);
    end
  endtask

  task automatic test_halt();
    logic [20:0] halt_word;
    halt_word = {HALT_OP, 15'd3};
    fill_ram_linear();
    ram[3] = halt_word;
    apply_reset();
    step(1, 0, 0, 6'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 6'd0);
    checks++; if (bus.ir_out !== halt_word || bus.ir_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL halt_present: got ir=%0h valid=%b expected ir=%0h valid=1", bus.ir_out, bus.ir_valid, halt_word);
    end
    step(1, 0, 0, 6'd0);
    checks++; if (bus.halted !== 1'b1 || bus.pc_out !== 6'd3 || bus.ir_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_state: got halted=%b pc=%0d valid=%b busy=%b expected 1 3 0 0", bus.halted, bus.pc_out, bus.ir_valid, bus.busy);
    end
    step(1, 0, 0, 6'd0);
    checks++; if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.addr_err !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_sticky: got halted=%b busy=%b err=%b expected 1 0 0", bus.halted, bus.busy, bus.addr_err);
    end
    ram[3] = 21'd3;
  endtask

  task automatic test_range_load();
    fill_ram_linear();
    apply_reset();
    step(1, 0, 0, 6'd0);
    step(0, 0, 0, 6'd0);
    step(0, 0, 0, 6'd0);
    step(0, 0, 1, 6'd60);
    checks++; if (bus.addr_err !== 1'b1 || bus.halted !== 1'b1 || bus.ir_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL range_load: got err=%b halted=%b valid=%b expected 1 1 0", bus.addr_err, bus.halted, bus.ir_valid);
    end
  endtask

  task automatic test_range_end();
    fill_ram_linear();
    apply_reset();
    step(1, 0, 0, 6'd0);
    for (int i = 0; i < MEM_DEPTH; i++) begin
      step(0, 0, 0, 6'd0);
      if (i == MEM_DEPTH - 2) begin
        checks++; if (bus.addr_err !== 1'b0 || bus.pc_out !== 6'(MEM_DEPTH - 1)) begin
          errors++; $display("[TB] FAIL range_before: got err=%b pc=%0d expected err=0 pc=%0d", bus.addr_err, bus.pc_out, MEM_DEPTH - 1);
        end
      end
    end
    checks++; if (bus.ir_out !== 21'(MEM_DEPTH - 1) || bus.ir_valid !== 1'b1 || bus.addr_err !== 1'b1 || bus.pc_out !== 6'(MEM_DEPTH - 1)) begin
      errors++; $display("[TB] FAIL range_last: got ir=%0d valid=%b err=%b pc=%0d expected ir=%0d valid=1 err=1 pc=%0d",
                         bus.ir_out, bus.ir_valid, bus.addr_err, bus.pc_out, MEM_DEPTH - 1, MEM_DEPTH - 1);
    end
    step(0, 0, 0, 6'd0);
    checks++; if (bus.ir_valid !== 1'b0 || bus.halted !== 1'b1) begin
      errors++; $display("[TB] FAIL range_after: got valid=%b halted=%b expected 0 1", bus.ir_valid, bus.halted);
    end
  endtask

  task automatic test_async_reset();
    fill_ram_linear();
    apply_reset();
    step(1, 0, 0, 6'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 6'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pc_out !== 6'd0 || bus.ir_out !== 21'd0 || bus.ir_valid !== 1'b0 || bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.addr_err !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset: got pc=%0d ir=%0d valid=%b busy=%b halted=%b err=%b expected all zero",
                         bus.pc_out, bus.ir_out, bus.ir_valid, bus.busy, bus.halted, bus.addr_err);
    end
`ifdef INST_FETCH_PERF_EN
    checks++; if (bus.fetch_cnt !== 16'd0 || bus.stall_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL async_reset_cnt: got fetch=%0d stall=%0d expected 0 0", bus.fetch_cnt, bus.stall_cnt);
    end
`endif
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit st, sl, ld;
    logic [5:0] val;
    for (int run = 0; run < 8; run++) begin
      for (int a = 0; a < 64; a++) ram[a] = 21'($urandom);
      apply_reset();
      step(1, 0, 0, 6'd0);
      for (int cyc = 0; cyc < 150; cyc++) begin
        st  = ($urandom_range(0, 19) == 0);
        sl  = ($urandom_range(0, 3) == 0);
        ld  = ($urandom_range(0, 11) == 0);
        val = 6'($urandom_range(0, 57));
        step(st, sl, ld, val);
        checks++; if (bus.pc_out !== 6'(m_pc)) begin errors++; $display("[TB] FAIL rand_pc: got %0d expected %0d", bus.pc_out, m_pc); end
        checks++; if (bus.ir_out !== m_ir) begin errors++; $display("[TB] FAIL rand_ir: got %0h expected %0h", bus.ir_out, m_ir); end
        checks++; if (bus.ir_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid: got %b expected %b", bus.ir_valid, m_valid); end
        checks++; if (bus.halted !== (m_mode == M_HALT)) begin errors++; $display("[TB] FAIL rand_halted: got %b expected %b", bus.halted, m_mode == M_HALT); end
        checks++; if (bus.addr_err !== m_err) begin errors++; $display("[TB] FAIL rand_err: got %b expected %b", bus.addr_err, m_err); end
        checks++; if (bus.busy !== (m_mode == M_RUN)) begin errors++; $display("[TB] FAIL rand_busy: got %b expected %b", bus.busy, m_mode == M_RUN); end
`ifdef INST_FETCH_PERF_EN
        checks++; if (bus.fetch_cnt !== 16'(m_fetch)) begin errors++; $display("[TB] FAIL rand_fetch_cnt: got %0d expected %0d", bus.fetch_cnt, m_fetch); end
        checks++; if (bus.stall_cnt !== 16'(m_stall)) begin errors++; $display("[TB] FAIL rand_stall_cnt: got %0d expected %0d", bus.stall_cnt, m_stall); end
`endif
      end
    end
  endtask

  initial begin
    bus.start = 0; bus.stall = 0; bus.pc_load = 0; bus.pc_load_val = '0;
    fill_ram_linear();
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_priority();
    test_halt();
    test_range_load();
    test_range_end();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: got no completion expected finish before 1ms");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Per-core fetch stage between the core control unit and one read port of the shared instruction RAM.
- Owns the core's 6-bit PC, drives it to the RAM port, and registers the returned 21-bit instruction into an instruction register (IR) for decode.
- Supports stall, PC load for jumps/branches with a one-cycle flush, halt-opcode detection and an out-of-range address trap.
- Four instances exist, one per core, each wired to its own PCn/INS_n pair.

Parameters:
- MEM_DEPTH, 52: number of valid instruction words; legal PC range is 0..MEM_DEPTH-1.
- START_PC, 0: PC loaded on reset and on start.
- HALT_OP, 6'b000100: opcode value in INS[20:15] that ends fetching.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins fetching from START_PC when IDLE.
- stall  in  1  hold PC, IR and ir_valid unchanged.
- pc_load  in  1  jump/branch taken; load pc_load_val.
- pc_load_val  in  6  jump target.
- pc_out  out  6  address to the instruction RAM port (combinational RAM read).
- ins_in  in  21  instruction word returned by the RAM for pc_out.
- ir_out  out  21  registered instruction to decode.
- ir_valid  out  1  ir_out holds a fresh, non-flushed instruction.
- halted  out  1  core has fetched HALT_OP or trapped.
- addr_err  out  1  sticky; PC left the legal range.
- busy  out  1  high in FETCH or STALL state.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc_out=START_PC, ir_out=0, ir_valid=0, halted=0, addr_err=0, busy=0.
- States are IDLE, FETCH, STALL and HALT.
- IDLE:
  - start=1 → FETCH, pc=START_PC.
  - All other inputs are ignored.
- FETCH, evaluated each cycle with priority pc_load > stall > normal:
  - Normal: ir_out<=ins_in, ir_valid<=1, pc<=pc+1. Latency: an instruction at address A appears on ir_out the cycle after pc_out=A.
  - pc_load: pc<=pc_load_val, ir_valid<=0 (flush), ir_out unchanged, stay FETCH. The first target instruction is valid 2 cycles after the pc_load cycle.
  - stall (and no pc_load): → STALL; pc, ir_out and ir_valid held.
- STALL:
  - Holds everything while stall=1.
  - stall=0 → FETCH, resuming at the held pc with no duplicate or skipped instruction.
  - pc_load during STALL: loads pc, clears ir_valid, and stays STALL if stall=1.
- Halt detection:
  - When an instruction with ins_in[20:15]==HALT_OP is captured, it is still presented (ir_valid=1 for that cycle).
  - Next state is HALT and pc is not incremented.
- Range trap:
  - If the normal increment would produce pc ≥ MEM_DEPTH, do the capture for the current word, then set addr_err=1, go to HALT, and hold pc at MEM_DEPTH-1.
  - pc_load_val ≥ MEM_DEPTH sets addr_err=1 and goes to HALT immediately, with ir_valid=0.
- HALT:
  - halted=1, ir_valid=0 from the cycle after entry, busy=0.
  - Only rst_n exits HALT; start is ignored.
- PC arithmetic: 6-bit unsigned; no wrap-around is ever permitted (the trap above applies instead).
- Reset mid-operation: all outputs go to reset values immediately and asynchronously, and any in-flight instruction is dropped.
- start received while not in IDLE is ignored.

Optional Feature:
- Macro: INST_FETCH_PERF_EN.
- When defined:
  - Adds output fetch_cnt (16 bits): count of cycles with ir_valid=1.
  - Adds output stall_cnt (16 bits): count of cycles spent in STALL.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- Sequential fetch: reset, start pulse, RAM model returns word=addr → ir_out shows 0,1,2,… on consecutive cycles with ir_valid=1; the first word arrives 1 cycle after pc_out=0.
- Stall: assert stall for 3 cycles while pc_out=5 → pc_out stays 5 and ir_out stays word 4 throughout; after release the next ir_out is word 5 with no gap or duplicate.
- Jump: pc_load=1, pc_load_val=20 at pc=7 → next cycle ir_valid=0 and pc_out=20; the following cycle ir_out=word 20.
- Priority: pc_load and stall together with target 10 → pc=10, ir_valid=0, state STALL; releasing stall leads to word 10 on ir_out.
- Halt/range: word 3 with opcode 6'b000100 → word 3 presented once, then halted=1, pc_out=3, ir_valid=0. Separately, pc_load_val=60 → addr_err=1 and halted=1.
- Async reset: drop rst_n mid-FETCH, off-clock-edge → all outputs reach reset values before the next edge. With INST_FETCH_PERF_EN, fetch_cnt equals the number of valid cycles observed.
